// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divider.
// Contents: operand width, divider FSM state enum, captured request payload,
// and the architectural results for divide-by-zero and signed overflow.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    // Request latched on the acceptance edge
    typedef struct packed {
        logic [XLEN-1:0] dividend;
        logic [XLEN-1:0] divisor;
        logic            is_signed;
        logic            want_rem;
    } div_req_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_QUOT  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   part_rem   - partial remainder before this step
//   next_bit   - next dividend bit shifted into the remainder
//   divisor    - divisor magnitude
//   new_rem_c  - partial remainder after this step
//   quot_bit_c - quotient bit produced by this step
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] part_rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] new_rem_c,
    output logic            quot_bit_c
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // Shift, trial-subtract, keep the difference only if it did not underflow
    always_comb begin
        shifted    = {part_rem, next_bit};
        diff       = XLEN'(shifted - {1'b0, divisor});
        quot_bit_c = (shifted >= {1'b0, divisor});
        new_rem_c  = quot_bit_c ? diff : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/divider_top.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring, one bit per cycle.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-low reset
//   div_en_i - start request (taken only in IDLE, not in the done_o cycle)
//   op_A_i   - dividend
//   op_B_i   - divisor
//   signed_i - 1: DIV/REM, 0: DIVU/REMU
//   rem_i    - 1: return remainder, 0: return quotient
//   result_o - quotient or remainder, held until the next completion
//   done_o   - one-cycle completion pulse
//   busy_o   - operation in flight
// Configuration macro: DIV_SPECIAL_BYPASS_EN - when defined, divide-by-zero and
// signed overflow skip the iteration phase (PREP goes straight to FIX).
module divider_top #(
    parameter int unsigned XLEN = rv32m_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            div_en_i,
    input  logic [XLEN-1:0] op_A_i,
    input  logic [XLEN-1:0] op_B_i,
    input  logic            signed_i,
    input  logic            rem_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o
);

    import rv32m_pkg::*;

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    div_state_e      state_q;
    div_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    div_req_t        req_q;

    logic [XLEN-1:0] abs_b_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] prem_q;
    logic            a_neg_q;
    logic            q_neg_q;
    logic            div0_q;
    logic            ovf_q;

    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] abs_a_c;
    logic [XLEN-1:0] abs_b_c;
    logic            div0_c;
    logic            ovf_c;
    logic [XLEN-1:0] step_rem_c;
    logic            step_bit_c;
    logic [XLEN-1:0] fix_quot_c;
    logic [XLEN-1:0] fix_rem_c;

    // Operand preparation from the captured request
    always_comb begin
        a_neg_c = req_q.is_signed & req_q.dividend[XLEN-1];
        b_neg_c = req_q.is_signed & req_q.divisor[XLEN-1];
        abs_a_c = a_neg_c ? XLEN'(-req_q.dividend) : req_q.dividend;
        abs_b_c = b_neg_c ? XLEN'(-req_q.divisor)  : req_q.divisor;
        div0_c  = (req_q.divisor == '0);
        ovf_c   = req_q.is_signed
                  && (req_q.dividend == XLEN'(OVF_QUOT))
                  && (req_q.divisor  == XLEN'(DIV0_QUOT));
    end

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .part_rem  (prem_q),
        .next_bit  (quot_q[XLEN-1]),
        .divisor   (abs_b_q),
        .new_rem_c (step_rem_c),
        .quot_bit_c(step_bit_c)
    );

    // Sign correction; special cases override the iterated values
    always_comb begin
        fix_quot_c = q_neg_q ? XLEN'(-quot_q) : quot_q;
        fix_rem_c  = a_neg_q ? XLEN'(-prem_q) : prem_q;
        if (div0_q) begin
            fix_quot_c = XLEN'(DIV0_QUOT);
            fix_rem_c  = req_q.dividend;
        end else if (ovf_q) begin
            fix_quot_c = XLEN'(OVF_QUOT);
            fix_rem_c  = '0;
        end
    end

    // Next-state logic; the done_o cycle never accepts a new request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (div_en_i && !done_o) begin
                    state_d = PREP;
                end
            end
            PREP: begin
                state_d = CALC;
`ifdef DIV_SPECIAL_BYPASS_EN
                if (div0_c || ovf_c) begin
                    state_d = FIX;
                end
`endif
            end
            CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q    <= '0;
            req_q    <= '0;
            abs_b_q  <= '0;
            quot_q   <= '0;
            prem_q   <= '0;
            a_neg_q  <= 1'b0;
            q_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_o <= '0;
            done_o   <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            // done_o trails the DONE state by one edge
            done_o <= (state_q == DONE);
            busy_o <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (state_d == PREP) begin
                        req_q.dividend  <= op_A_i;
                        req_q.divisor   <= op_B_i;
                        req_q.is_signed <= signed_i;
                        req_q.want_rem  <= rem_i;
                    end
                end
                PREP: begin
                    a_neg_q <= a_neg_c;
                    q_neg_q <= a_neg_c ^ b_neg_c;
                    div0_q  <= div0_c;
                    ovf_q   <= ovf_c;
                    abs_b_q <= abs_b_c;
                    quot_q  <= abs_a_c;
                    prem_q  <= '0;
                    cnt_q   <= '0;
                end
                CALC: begin
                    // Dividend bits shift out of quot_q as quotient bits shift in
                    prem_q <= step_rem_c;
                    quot_q <= {quot_q[XLEN-2:0], step_bit_c};
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    result_o <= req_q.want_rem ? fix_rem_c : fix_quot_c;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_top.sv
// Self-checking bench for divider_top: directed vector table plus hand-written
// sequences for reset behaviour and request handling while busy.
module tb_divider_top;

    localparam int NOM_LAT = 35;
`ifdef DIV_SPECIAL_BYPASS_EN
    localparam int SPEC_LAT = 3;
`else
    localparam int SPEC_LAT = 35;
`endif
    localparam int MAX_WAIT = 60;
    localparam int NVEC = 22;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        div_en_i;
    logic [31:0] op_A_i;
    logic [31:0] op_B_i;
    logic        signed_i;
    logic        rem_i;
    logic [31:0] result_o;
    logic        done_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    divider_top dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .div_en_i(div_en_i),
        .op_A_i  (op_A_i),
        .op_B_i  (op_B_i),
        .signed_i(signed_i),
        .rem_i   (rem_i),
        .result_o(result_o),
        .done_o  (done_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        rem;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One operation; lat counts edges after the acceptance edge until done_o is seen
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                         output logic [31:0] res, output int lat);
        bit got;
        repeat (2) @(negedge clk_i);
        op_A_i = a; op_B_i = b; signed_i = s; rem_i = r; div_en_i = 1'b1;
        @(posedge clk_i);
        #1 div_en_i = 1'b0;
        res = '0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < MAX_WAIT) begin
            @(posedge clk_i);
            lat++;
            #1;
            if (done_o) begin
                got = 1'b1;
                res = result_o;
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] hres;
        int lat;
        int ndone;
        int first_lat;
        bit stop;

        vecs[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, 32'd14,       NOM_LAT};
        vecs[1]  = '{32'd100,      32'd7,        1'b0, 1'b1, 32'd2,        NOM_LAT};
        vecs[2]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, 32'hFFFFFFFD, NOM_LAT};
        vecs[3]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFF, NOM_LAT};
        vecs[4]  = '{32'h12345678, 32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, SPEC_LAT};
        vecs[5]  = '{32'h12345678, 32'd0,        1'b1, 1'b1, 32'h12345678, SPEC_LAT};
        vecs[6]  = '{32'h12345678, 32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, SPEC_LAT};
        vecs[7]  = '{32'h12345678, 32'd0,        1'b0, 1'b1, 32'h12345678, SPEC_LAT};
        vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, SPEC_LAT};
        vecs[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, SPEC_LAT};
        vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, NOM_LAT};
        vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, NOM_LAT};
        vecs[12] = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, NOM_LAT};
        vecs[13] = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'd1,        NOM_LAT};
        vecs[14] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd3,        NOM_LAT};
        vecs[15] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFF, NOM_LAT};
        vecs[16] = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'hFFFFFFFF, NOM_LAT};
        vecs[17] = '{32'hFFFFFFFF, 32'd10,       1'b0, 1'b0, 32'h19999999, NOM_LAT};
        vecs[18] = '{32'hFFFFFFFF, 32'd10,       1'b0, 1'b1, 32'd5,        NOM_LAT};
        vecs[19] = '{32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, SPEC_LAT};
        vecs[20] = '{32'hFFFFFFFF, 32'd0,        1'b1, 1'b1, 32'hFFFFFFFF, SPEC_LAT};
        vecs[21] = '{32'd0,        32'd5,        1'b0, 1'b0, 32'd0,        NOM_LAT};

        // Reset with a request pending: must stay idle
        rst_i = 1'b0; div_en_i = 1'b1;
        op_A_i = 32'd5; op_B_i = 32'd1; signed_i = 1'b0; rem_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset result_o", result_o, 32'd0);
        check("reset done_o", 32'(done_o), 32'd0);
        check("reset busy_o", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1; div_en_i = 1'b0;
        @(posedge clk_i);
        #1 check("request during reset ignored", 32'(busy_o), 32'd0);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rem, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Reset at edge 10 of a DIVU operation
        repeat (2) @(negedge clk_i);
        op_A_i = 32'd1000; op_B_i = 32'd3; signed_i = 1'b0; rem_i = 1'b0; div_en_i = 1'b1;
        @(posedge clk_i);
        #1 div_en_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 check("busy mid-op", 32'(busy_o), 32'd1);
        repeat (4) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("abort busy_o", 32'(busy_o), 32'd0);
        check("abort result_o", result_o, 32'd0);
        check("abort done_o", 32'(done_o), 32'd0);
        rst_i = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1 if (done_o) ndone++;
        end
        check("abort no done pulse", 32'(ndone), 32'd0);
        do_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
        check("after abort DIVU 9/3", res, 32'd3);
        check("after abort latency", 32'(lat), 32'(NOM_LAT));

        // div_en_i held high with operands changing every cycle
        repeat (2) @(negedge clk_i);
        op_A_i = 32'd200; op_B_i = 32'd10; signed_i = 1'b0; rem_i = 1'b0; div_en_i = 1'b1;
        @(posedge clk_i);
        ndone = 0; first_lat = 0; hres = '0; stop = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk_i);
            if (!stop) begin
                op_A_i   = $urandom;
                op_B_i   = $urandom;
                signed_i = 1'($urandom);
                rem_i    = 1'($urandom);
            end
            @(posedge clk_i);
            #1;
            if (c == 5)  check("hold busy", 32'(busy_o), 32'd1);
            if (c == 20) check("hold previous result kept", result_o, 32'd3);
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = c;
                    hres = result_o;
                end
                stop = 1'b1;
                div_en_i = 1'b0;
            end
        end
        check("hold single done", 32'(ndone), 32'd1);
        check("hold captured result", hres, 32'd20);
        check("hold latency", 32'(first_lat), 32'(NOM_LAT));
        check("hold idle afterwards", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_top.md
DIVIDER_TOP -- requirements
Module: divider_top

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port div_en_i  input  1  start request from the decoder's div_on_o.
REQ-005 The block SHALL have port op_A_i  input  XLEN  dividend.
REQ-006 The block SHALL have port op_B_i  input  XLEN  divisor.
REQ-007 The block SHALL have port signed_i  input  1  1 selects DIV/REM, 0 selects DIVU/REMU.
REQ-008 The block SHALL have port rem_i  input  1  1 returns the remainder, 0 returns the quotient (decoder upper_rem_o).
REQ-009 The block SHALL have port result_o  output  XLEN  quotient or remainder.
REQ-010 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port busy_o  output  1  high while an operation is in flight.

Function
REQ-012 The FSM SHALL have states IDLE, PREP, CALC, FIX and DONE.
REQ-013 In IDLE, div_en_i=1 at a rising edge SHALL capture op_A_i, op_B_i, signed_i and rem_i and move to PREP; input changes after that edge SHALL have no effect.
REQ-014 PREP SHALL take absolute values of signed operands, record the result signs and flag divide-by-zero (B=0) and signed overflow (A=0x80000000, B=0xFFFFFFFF), lasting 1 cycle.
REQ-015 CALC SHALL perform exactly XLEN restoring iterations, one per cycle, using a 5-bit iteration counter, then go to FIX.
REQ-016 FIX SHALL apply sign correction: quotient negated if the operand signs differ, remainder takes the sign of the dividend. It lasts 1 cycle.
REQ-017 Divide-by-zero SHALL produce quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned.
REQ-018 Signed overflow SHALL produce quotient 0x80000000 and remainder 0.
REQ-019 DONE SHALL hold done_o=1 for exactly one cycle, then return to IDLE.
REQ-020 result_o SHALL be updated when FIX exits and held until the next DONE.
REQ-021 Nominal latency SHALL be: done_o high in the cycle following the 35th rising edge after the acceptance edge.
REQ-022 busy_o SHALL be 1 in PREP, CALC, FIX and DONE, and 0 in IDLE.
REQ-023 div_en_i SHALL be ignored while busy_o=1; DONE to IDLE SHALL NOT itself accept a request, and acceptance is earliest one cycle after done_o.

Reset
REQ-024 rst_i=0 at a rising edge SHALL force IDLE, result_o=0, done_o=0, busy_o=0 and counter=0, including mid-operation; an aborted operation SHALL never assert done_o.
REQ-025 A request presented while rst_i=0 SHALL be ignored.

Configuration
REQ-026 Macro DIV_SPECIAL_BYPASS_EN, when defined, SHALL route divide-by-zero and overflow from PREP directly to FIX, so done_o rises 3 edges after acceptance.
REQ-027 Without DIV_SPECIAL_BYPASS_EN, special cases SHALL traverse all CALC iterations, with the nominal latency and identical results.

Structure
REQ-028 Package rv32m_pkg SHALL hold XLEN, the FSM state enum, and the constants DIV0_QUOT (all ones) and OVF_QUOT (0x80000000).
REQ-029 One combinational sub-module div_step SHALL implement a single restoring iteration: shift the partial remainder, subtract the divisor, select the result and produce the quotient bit. It is instantiated once.

Verification
REQ-030 DIVU 100/7 SHALL return result_o=14 with done_o at edge 35; REMU with the same operands SHALL return 2.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) SHALL return 0xFFFFFFFD; REM with the same operands SHALL return 0xFFFFFFFF.
REQ-032 DIV 0x12345678/0 SHALL return 0xFFFFFFFF and REM SHALL return 0x12345678; latency SHALL be 35 edges without the macro and 3 edges with it.
REQ-033 DIV 0x80000000/0xFFFFFFFF SHALL return 0x80000000; REM with the same operands SHALL return 0.
REQ-034 rst_i=0 at edge 10 of a DIVU operation SHALL give no done_o, result_o=0 and busy_o=0; a following DIVU 9/3 SHALL return 3.
REQ-035 Holding div_en_i=1 with changing operands throughout an operation SHALL produce exactly one done_o, carrying the result for the originally captured operands.
